// File: rtl/p405s_timer_event_gen.sv
// Timer event producer: FIT/WD tap edge detection, PIT down-counter and the
// one-cycle TSR set requests, plus the held watchdog reset request.
module p405s_timer_event_gen #(
    parameter int TB_W  = 32,
    parameter int PIT_W = 32
) (
    input  logic             CB,
    input  logic             resetCore,
    input  logic [0:TB_W-1]  tbLow,
    input  logic             tbTick,
    input  logic [1:0]       fitPeriodSel,
    input  logic [1:0]       wdPeriodSel,
    input  logic [1:0]       wdRstCtl,
    input  logic             pitAutoReload,
    input  logic             pitLoad,
    input  logic [PIT_W-1:0] pitLoadData,
    input  logic             tsrEnw,
    input  logic             tsrWis,
    output logic             hwSetFitStatus,
    output logic             hwSetPitStatus,
    output logic             wdPulse,
    output logic             hwSetWdIntrp,
    output logic             hwSetWdRst,
    output logic [1:0]       wdRstType,
    output logic             wdRstReq,
    output logic [PIT_W-1:0] pitValue
);

    logic             fit_tap, wd_tap, fit_edge, wd_edge;
    logic             armed_q, armed_d;
    logic             fit_tap_q, fit_tap_d, wd_tap_q, wd_tap_d;
    logic [1:0]       fit_sel_q, fit_sel_d, wd_sel_q, wd_sel_d;
    logic             fit_set_q, fit_set_d, pit_set_q, pit_set_d;
    logic             wd_pulse_q, wd_pulse_d, wd_intrp_q, wd_intrp_d;
    logic             wd_rst_q, wd_rst_d, wd_req_q, wd_req_d;
    logic [1:0]       wd_type_q, wd_type_d;
    logic [PIT_W-1:0] pit_q, pit_d, reload_q, reload_d;

    // Time-base bit 2^k lives at index TB_W-1-k (bit 0 is the MSB).
    always_comb begin
        case (fitPeriodSel)
            2'b00:   fit_tap = tbLow[TB_W-1-9];
            2'b01:   fit_tap = tbLow[TB_W-1-13];
            2'b10:   fit_tap = tbLow[TB_W-1-17];
            default: fit_tap = tbLow[TB_W-1-21];
        endcase
        case (wdPeriodSel)
            2'b00:   wd_tap = tbLow[TB_W-1-17];
            2'b01:   wd_tap = tbLow[TB_W-1-21];
            2'b10:   wd_tap = tbLow[TB_W-1-25];
            default: wd_tap = tbLow[TB_W-1-29];
        endcase
    end

    // armed_q suppresses the first sample after reset, so a tap already high
    // when reset drops must fall and rise again before it counts as an edge.
    assign fit_edge = armed_q & fit_tap & ~fit_tap_q & (fitPeriodSel == fit_sel_q);
    assign wd_edge  = armed_q & wd_tap & ~wd_tap_q & (wdPeriodSel == wd_sel_q);

    always_comb begin
        armed_d    = 1'b1;
        fit_tap_d  = fit_tap;
        fit_sel_d  = fitPeriodSel;
        wd_tap_d   = wd_tap;
        wd_sel_d   = wdPeriodSel;
        fit_set_d  = fit_edge;
        pit_d      = pit_q;
        reload_d   = reload_q;
        pit_set_d  = 1'b0;
        wd_pulse_d = 1'b0;
        wd_intrp_d = 1'b0;
        wd_rst_d   = 1'b0;
        wd_type_d  = wd_type_q;
        wd_req_d   = wd_req_q;

        if (pitLoad) begin
            pit_d    = pitLoadData;
            reload_d = pitLoadData;
        end else if (tbTick && (pit_q > PIT_W'(1))) begin
            pit_d = pit_q - PIT_W'(1);
        end else if (tbTick && (pit_q == PIT_W'(1))) begin
            pit_set_d = 1'b1;
            pit_d     = pitAutoReload ? reload_q : '0;
        end

        if (wd_edge) begin
            case ({tsrEnw, tsrWis})
                2'b00, 2'b01: wd_pulse_d = 1'b1;
                2'b10:        wd_intrp_d = 1'b1;
                default: begin
                    if ((wdRstCtl != 2'b00) && !wd_req_q) begin
                        wd_rst_d  = 1'b1;
                        wd_type_d = wdRstCtl;
                        wd_req_d  = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CB or posedge resetCore) begin
        if (resetCore) begin
            armed_q    <= 1'b0;
            fit_tap_q  <= 1'b0;
            fit_sel_q  <= 2'b00;
            wd_tap_q   <= 1'b0;
            wd_sel_q   <= 2'b00;
            fit_set_q  <= 1'b0;
            pit_q      <= '0;
            reload_q   <= '0;
            pit_set_q  <= 1'b0;
            wd_pulse_q <= 1'b0;
            wd_intrp_q <= 1'b0;
            wd_rst_q   <= 1'b0;
            wd_type_q  <= 2'b00;
            wd_req_q   <= 1'b0;
        end else begin
            armed_q    <= armed_d;
            fit_tap_q  <= fit_tap_d;
            fit_sel_q  <= fit_sel_d;
            wd_tap_q   <= wd_tap_d;
            wd_sel_q   <= wd_sel_d;
            fit_set_q  <= fit_set_d;
            pit_q      <= pit_d;
            reload_q   <= reload_d;
            pit_set_q  <= pit_set_d;
            wd_pulse_q <= wd_pulse_d;
            wd_intrp_q <= wd_intrp_d;
            wd_rst_q   <= wd_rst_d;
            wd_type_q  <= wd_type_d;
            wd_req_q   <= wd_req_d;
        end
    end

    assign hwSetFitStatus = fit_set_q;
    assign hwSetPitStatus = pit_set_q;
    assign wdPulse        = wd_pulse_q;
    assign hwSetWdIntrp   = wd_intrp_q;
    assign hwSetWdRst     = wd_rst_q;
    assign wdRstType      = wd_type_q;
    assign wdRstReq       = wd_req_q;
    assign pitValue       = pit_q;

endmodule

// File: tb/tb_p405s_timer_event_gen.sv
// Directed bench for p405s_timer_event_gen: FIT/WD edges, PIT sequencing,
// watchdog escalation and asynchronous reset.
module tb_p405s_timer_event_gen;

    localparam int TB_W  = 32;
    localparam int PIT_W = 32;

    logic             CB = 1'b0;
    logic             resetCore;
    logic [0:TB_W-1]  tbLow;
    logic             tbTick;
    logic [1:0]       fitPeriodSel, wdPeriodSel, wdRstCtl;
    logic             pitAutoReload, pitLoad;
    logic [PIT_W-1:0] pitLoadData;
    logic             tsrEnw, tsrWis;
    logic             hwSetFitStatus, hwSetPitStatus, wdPulse, hwSetWdIntrp, hwSetWdRst;
    logic [1:0]       wdRstType;
    logic             wdRstReq;
    logic [PIT_W-1:0] pitValue;

    int checks   = 0;
    int failures = 0;

    always #5 CB = ~CB;

    p405s_timer_event_gen #(.TB_W(TB_W), .PIT_W(PIT_W)) dut (
        .CB(CB), .resetCore(resetCore), .tbLow(tbLow), .tbTick(tbTick),
        .fitPeriodSel(fitPeriodSel), .wdPeriodSel(wdPeriodSel), .wdRstCtl(wdRstCtl),
        .pitAutoReload(pitAutoReload), .pitLoad(pitLoad), .pitLoadData(pitLoadData),
        .tsrEnw(tsrEnw), .tsrWis(tsrWis),
        .hwSetFitStatus(hwSetFitStatus), .hwSetPitStatus(hwSetPitStatus),
        .wdPulse(wdPulse), .hwSetWdIntrp(hwSetWdIntrp), .hwSetWdRst(hwSetWdRst),
        .wdRstType(wdRstType), .wdRstReq(wdRstReq), .pitValue(pitValue)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CB);
        #1;
    endtask

    task automatic set_tb(input int k, input logic v);
        tbLow[TB_W-1-k] = v;
    endtask

    task automatic check_wd(input string tag, input logic p, input logic i, input logic r);
        check({tag, "_wdPulse"}, 64'(wdPulse), 64'(p));
        check({tag, "_intrp"}, 64'(hwSetWdIntrp), 64'(i));
        check({tag, "_rst"}, 64'(hwSetWdRst), 64'(r));
    endtask

    task automatic wd_edge(input logic enw, input logic wis);
        tsrEnw = enw;
        tsrWis = wis;
        set_tb(17, 1'b0);
        tick();
        set_tb(17, 1'b1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        resetCore = 1'b1; tbLow = '0; tbTick = 1'b0;
        fitPeriodSel = 2'b00; wdPeriodSel = 2'b00; wdRstCtl = 2'b10;
        pitAutoReload = 1'b0; pitLoad = 1'b0; pitLoadData = '0;
        tsrEnw = 1'b0; tsrWis = 1'b0;
        tick(); tick();
        check("rst_pit", 64'(pitValue), 64'd0);
        check("rst_fit", 64'(hwSetFitStatus), 64'd0);
        check("rst_req", 64'(wdRstReq), 64'd0);
        check("rst_type", 64'(wdRstType), 64'd0);
        resetCore = 1'b0;
        tick(); tick();

        // FIT edge on 2^9 with FP=00
        set_tb(9, 1'b1);
        tick();
        check("fit_edge", 64'(hwSetFitStatus), 64'd1);
        tick();
        check("fit_one_cycle", 64'(hwSetFitStatus), 64'd0);

        // select change in the same cycle as the new tap rising
        tbLow = '0;
        tick();
        fitPeriodSel = 2'b01;
        set_tb(13, 1'b1);
        tick();
        check("fit_selchg", 64'(hwSetFitStatus), 64'd0);
        tick();
        check("fit_selchg_next", 64'(hwSetFitStatus), 64'd0);
        tbLow = '0;
        tick();

        // PIT auto-reload
        pitAutoReload = 1'b1; pitLoad = 1'b1; pitLoadData = 32'd3;
        tick();
        check("pit_load3", 64'(pitValue), 64'd3);
        pitLoad = 1'b0; tbTick = 1'b1;
        tick();
        check("pit_are_2", 64'(pitValue), 64'd2);
        check("pit_are_nost2", 64'(hwSetPitStatus), 64'd0);
        tick();
        check("pit_are_1", 64'(pitValue), 64'd1);
        tick();
        check("pit_are_reload", 64'(pitValue), 64'd3);
        check("pit_are_status", 64'(hwSetPitStatus), 64'd1);
        tbTick = 1'b0;
        tick();
        check("pit_are_status_drop", 64'(hwSetPitStatus), 64'd0);

        // PIT without auto-reload
        pitAutoReload = 1'b0; pitLoad = 1'b1; pitLoadData = 32'd3;
        tick();
        pitLoad = 1'b0; tbTick = 1'b1;
        tick();
        check("pit_nare_2", 64'(pitValue), 64'd2);
        tick();
        check("pit_nare_1", 64'(pitValue), 64'd1);
        tick();
        check("pit_nare_0", 64'(pitValue), 64'd0);
        check("pit_nare_status", 64'(hwSetPitStatus), 64'd1);
        tick();
        check("pit_hold_0", 64'(pitValue), 64'd0);
        check("pit_hold_nost", 64'(hwSetPitStatus), 64'd0);

        // load wins over tick; loading 1 then pulses on next tick
        pitLoad = 1'b1; pitLoadData = 32'd7;
        tick();
        check("pit_load_tick", 64'(pitValue), 64'd7);
        pitLoadData = 32'd1;
        tick();
        check("pit_load1", 64'(pitValue), 64'd1);
        check("pit_load1_nost", 64'(hwSetPitStatus), 64'd0);
        pitLoad = 1'b0;
        tick();
        check("pit_load1_fire", 64'(hwSetPitStatus), 64'd1);
        check("pit_load1_zero", 64'(pitValue), 64'd0);
        tbTick = 1'b0;

        // Watchdog escalation, WP=00 -> 2^17, WRC=10
        wd_edge(1'b0, 1'b0);
        check_wd("wd00", 1'b1, 1'b0, 1'b0);
        wd_edge(1'b1, 1'b0);
        check_wd("wd10", 1'b0, 1'b1, 1'b0);
        wd_edge(1'b1, 1'b1);
        check_wd("wd11", 1'b0, 1'b0, 1'b1);
        check("wd11_type", 64'(wdRstType), 64'd2);
        check("wd11_req", 64'(wdRstReq), 64'd1);
        tick();
        check("wd_rst_one_cycle", 64'(hwSetWdRst), 64'd0);
        check("wd_req_held", 64'(wdRstReq), 64'd1);
        wd_edge(1'b1, 1'b1);
        check_wd("wd4th", 1'b0, 1'b0, 1'b0);
        check("wd4th_req", 64'(wdRstReq), 64'd1);
        tbLow = '0;
        tick();

        // PIT at 5 plus a FIT pulse in flight, then asynchronous reset
        pitLoad = 1'b1; pitLoadData = 32'd5;
        set_tb(13, 1'b1);
        tick();
        pitLoad = 1'b0;
        check("pre_rst_pit", 64'(pitValue), 64'd5);
        check("pre_rst_fit", 64'(hwSetFitStatus), 64'd1);
        #2;
        resetCore = 1'b1;
        #1;
        check("arst_pit", 64'(pitValue), 64'd0);
        check("arst_fit", 64'(hwSetFitStatus), 64'd0);
        check("arst_req", 64'(wdRstReq), 64'd0);
        check("arst_type", 64'(wdRstType), 64'd0);

        // tap already high when reset releases: no pulse until it re-rises
        fitPeriodSel = 2'b00;
        tbLow = '0;
        set_tb(9, 1'b1);
        tick();
        resetCore = 1'b0;
        tbTick = 1'b1;
        tick();
        check("post_rst_tap_hi", 64'(hwSetFitStatus), 64'd0);
        check("post_rst_pit_hold", 64'(pitValue), 64'd0);
        tick();
        check("post_rst_tap_hi2", 64'(hwSetFitStatus), 64'd0);
        tbTick = 1'b0;
        set_tb(9, 1'b0);
        tick();
        set_tb(9, 1'b1);
        tick();
        check("post_rst_rise", 64'(hwSetFitStatus), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
